// File: rtl/div_operand_queue.sv
// Operand FIFO in front of the combinational divider: buffers dividend/divisor
// pairs, tags each one with a wrapping sequence number and counts divide-by-zero requests.
module div_operand_queue #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 4,
  parameter int TAG_W    = 4,
  parameter int DZ_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_dividend,
  input  logic [WIDTH-1:0]         in_divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_dividend,
  output logic [WIDTH-1:0]         out_divisor,
  output logic                     out_div_zero,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DZ_CNT_W-1:0]      dz_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] dvd_mem [DEPTH];
  logic [WIDTH-1:0] dvs_mem [DEPTH];
  logic             dz_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic             push;
  logic             pop;
  logic             in_zero;

  // Both flags come from registered level only, so full blocks a push even with a pop.
  assign in_ready  = (level < LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_zero   = (in_divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      tag_cnt  <= '0;
      dz_count <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
        if (in_zero && (dz_count != '1)) begin
          dz_count <= dz_count + DZ_CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is never reset; outputs are masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      dvd_mem[wr_ptr] <= in_dividend;
      dvs_mem[wr_ptr] <= in_divisor;
      dz_mem[wr_ptr]  <= in_zero;
      tag_mem[wr_ptr] <= tag_cnt;
    end
  end

  assign out_dividend = out_valid ? dvd_mem[rd_ptr] : '0;
  assign out_divisor  = out_valid ? dvs_mem[rd_ptr] : '0;
  assign out_div_zero = out_valid ? dz_mem[rd_ptr]  : 1'b0;
  assign out_tag      = out_valid ? tag_mem[rd_ptr] : '0;

endmodule

// File: doc/div_operand_queue.md
Name: div_operand_queue

Overview:
- Upstream issue stage for the team's combinational 4-bit divider.
- Accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head pair to the divider with a divide-by-zero flag and a wrap-around sequence tag, so the result-capture logic can match quotient/remainder to the request.
- Keeps a saturating count of divide-by-zero requests for status readback.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- WIDTH, 4, operand width in bits; matches the divider's dividend/divisor width.
- TAG_W, 4, width of the sequence tag.
- DZ_CNT_W, 8, width of the saturating divide-by-zero counter.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a pair.
- in_ready  output  1  queue can accept a pair this cycle.
- in_dividend  input  WIDTH  dividend.
- in_divisor  input  WIDTH  divisor.
- out_valid  output  1  head pair is available to the divider.
- out_ready  input  1  downstream consumes the head pair this cycle.
- out_dividend  output  WIDTH  head dividend, drives the divider.
- out_divisor  output  WIDTH  head divisor, drives the divider.
- out_div_zero  output  1  head divisor equals 0.
- out_tag  output  TAG_W  sequence tag of the head pair.
- level  output  clog2(DEPTH)+1  number of occupied entries.
- dz_count  output  DZ_CNT_W  saturating count of accepted pairs with divisor 0.

Behaviour:
- Reset: rst_n low asynchronously clears the read pointer, write pointer, level, tag counter and dz_count. While in reset and immediately after release:
  - out_valid=0, in_ready=1, level=0, dz_count=0, out_tag=0, out_dividend=0, out_divisor=0, out_div_zero=0.
  - Storage contents need not be cleared, but outputs must read 0 while empty.
- Handshakes:
  - Push occurs on a rising edge when in_valid && in_ready.
  - Pop occurs on a rising edge when out_valid && out_ready.
- in_ready = (level < DEPTH). It is a registered-state function, with no combinational path from out_ready. Full therefore blocks a push even if a pop happens in the same cycle.
- out_valid = (level != 0).
- Output path:
  - Outputs come from the head entry's registers, first-word-fall-through.
  - Latency: a pair pushed at edge N appears on the outputs after edge N when the queue was empty. No same-cycle bypass from in_* to out_*.
- Hold: while out_valid && !out_ready, all out_* are stable.
- Entry contents stored per push: dividend, divisor, div_zero=(divisor==0), and the current tag value.
- Tag counter: increments by 1 on every push; wraps from 2^TAG_W-1 to 0. The first pair after reset gets tag 0.
- dz_count: increments on each push with divisor==0 and saturates at 2^DZ_CNT_W-1. A pop has no effect on it.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop with level=1: the new pair becomes head after the edge; out_valid stays 1.
- Empty with in_valid=1 and out_ready=1: the push happens, no pop; level becomes 1.
- Full with in_valid=1: no push, no tag increment, no dz_count change; upstream holds its data.
- Inputs are not checked for X; in_* are sampled only on a push.
- rst_n asserted mid-operation: all buffered pairs are discarded immediately. After release, behaviour is identical to power-on.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, level=0, dz_count=0, out_tag=0.
- Push (13,4) with out_ready=0 → after one edge: out_valid=1, out_dividend=13, out_divisor=4, out_div_zero=0, out_tag=0, level=1. Holding out_ready=0 for 5 cycles keeps the outputs unchanged.
- Push 4 pairs (9,0),(15,3),(7,0),(8,2) with out_ready=0:
  - After the 4th push: level=4, in_ready=0, dz_count=2.
  - A 5th in_valid pulse is not accepted.
  - Drain with out_ready=1 → pairs emerge in order with tags 0,1,2,3 and div_zero 1,0,1,0; level returns to 0.
- Continuous push+pop at level=1 for 20 cycles → level stays 1; tags observed run 0..15,0..3 (wrap); in_ready stays 1.
- Push 300 pairs with divisor 0 while draining → dz_count saturates at 255.
- With level=3, assert rst_n low for 1 cycle mid-stream → outputs return to reset values asynchronously; the next push gets tag 0 and level becomes 1.
